// File: rtl/regdst_scoreboard_if.sv
// -----------------------------------------------------------------------------
// regdst_scoreboard_if
// Issue / writeback / flush bundle between the decode-issue stage and the
// register write scoreboard.
//
//   issue_valid, issue_wr, issue_dst, issue_rs, issue_rt : issue request
//   issue_ready, stall                                   : issue response
//   wb_valid, wb_dst                                     : writeback completion
//   flush                                                : pipeline squash
//
// master : driven by the pipeline (decode/issue and writeback side)
// slave  : the scoreboard
// -----------------------------------------------------------------------------
interface regdst_scoreboard_if #(
    parameter int ADDR_W = 5
) ();
    logic              issue_valid;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_dst;
    logic [ADDR_W-1:0] issue_rs;
    logic [ADDR_W-1:0] issue_rt;
    logic              issue_ready;
    logic              stall;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_dst;
    logic              flush;

    modport master (
        output issue_valid, issue_wr, issue_dst, issue_rs, issue_rt,
        output wb_valid, wb_dst, flush,
        input  issue_ready, stall
    );

    modport slave (
        input  issue_valid, issue_wr, issue_dst, issue_rs, issue_rt,
        input  wb_valid, wb_dst, flush,
        output issue_ready, stall
    );
endinterface

// File: rtl/regdst_scoreboard.sv
// -----------------------------------------------------------------------------
// regdst_scoreboard
// Per-register outstanding-write tracker. Decodes the issue destination into a
// per-register counter, clears it at writeback and stalls issue on RAW hazards
// or when a destination counter is saturated.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   bus            regdst_scoreboard_if.slave (issue, writeback, flush)
//   pending_mask   registered, bit i set while register i has writes pending
//   total_pending  registered, sum of all counters (saturates at 127)
//   wb_underflow   sticky, writeback seen for a register with no pending write
//
// Build option:
//   WB_BYPASS_EN   when defined, a source hazard is dropped if that register's
//                  last pending write completes in the same cycle
// -----------------------------------------------------------------------------
module regdst_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,     // 2**ADDR_W must equal NUM_REGS
    parameter int CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regdst_scoreboard_if.slave   bus,
    output logic [NUM_REGS-1:0]  pending_mask,
    output logic [6:0]           total_pending,
    output logic                 wb_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Flattened view of every counter so it can be indexed by address.
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_all;
    logic [NUM_REGS-1:0]            nz_next;

    logic [CNT_W-1:0] cnt_rs, cnt_rt, cnt_dst, cnt_wb;
    logic             hz_rs, hz_rt, hz_sat;
    logic             stall_int;
    logic             issue_inc;
    logic             wb_hit;
    logic             same_reg;
    logic             dec_eff;

    logic [NUM_REGS-1:0] pending_mask_q, pending_mask_d;
    logic [6:0]          total_pending_q, total_pending_d;
    logic                wb_underflow_q, wb_underflow_d;
    logic [7:0]          total_sum;

    assign cnt_rs  = cnt_all[bus.issue_rs];
    assign cnt_rt  = cnt_all[bus.issue_rt];
    assign cnt_dst = cnt_all[bus.issue_dst];
    assign cnt_wb  = cnt_all[bus.wb_dst];

    // Hazard detection. cnt_all[0] is tied to zero, so register 0 can never
    // raise a hazard; the explicit address checks keep the intent visible.
    always_comb begin
        hz_rs  = (bus.issue_rs != '0) && (cnt_rs != '0);
        hz_rt  = (bus.issue_rt != '0) && (cnt_rt != '0);
`ifdef WB_BYPASS_EN
        // Last outstanding write lands this cycle and is forwarded.
        if (bus.wb_valid && (bus.wb_dst == bus.issue_rs) && (cnt_rs == CNT_ONE))
            hz_rs = 1'b0;
        if (bus.wb_valid && (bus.wb_dst == bus.issue_rt) && (cnt_rt == CNT_ONE))
            hz_rt = 1'b0;
`endif
        // Saturation is judged on the registered count; a same-cycle
        // writeback does not free a slot until the next cycle.
        hz_sat    = bus.issue_wr && (bus.issue_dst != '0) && (cnt_dst == CNT_MAX);
        stall_int = bus.issue_valid && (hz_rs || hz_rt || hz_sat);
    end

    assign bus.stall       = stall_int;
    assign bus.issue_ready = bus.issue_valid && !stall_int;

    assign issue_inc = bus.issue_valid && !stall_int && bus.issue_wr && (bus.issue_dst != '0);
    assign wb_hit    = bus.wb_valid && (bus.wb_dst != '0);
    assign same_reg  = issue_inc && wb_hit && (bus.issue_dst == bus.wb_dst);
    // A writeback really removes a pending write when the counter is nonzero,
    // or when it cancels an increment to the same register this cycle.
    assign dec_eff   = wb_hit && ((cnt_wb != '0) || same_reg);

    // ---------------- per-register counters ----------------
    assign cnt_all[0] = '0;
    assign nz_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             inc_hit, dec_hit;

            always_comb begin
                inc_hit = issue_inc && (bus.issue_dst == ADDR_W'(gi));
                dec_hit = wb_hit && (bus.wb_dst == ADDR_W'(gi));
                cnt_d   = cnt_q;
                if (bus.flush)
                    cnt_d = '0;
                else if (inc_hit && !dec_hit)
                    cnt_d = cnt_q + 1'b1;   // cannot wrap: saturation stalls
                else if (dec_hit && !inc_hit && (cnt_q != '0))
                    cnt_d = cnt_q - 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign cnt_all[gi] = cnt_q;
            assign nz_next[gi] = (cnt_d != '0);
        end
    endgenerate

    // ---------------- summary state ----------------
    always_comb begin
        total_sum       = {1'b0, total_pending_q} + {7'd0, issue_inc} - {7'd0, dec_eff};
        pending_mask_d  = nz_next;
        wb_underflow_d  = wb_underflow_q;
        if (bus.flush) begin
            total_pending_d = '0;
        end else begin
            total_pending_d = total_sum[7] ? 7'd127 : total_sum[6:0];
            if (wb_hit && (cnt_wb == '0) && !same_reg)
                wb_underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mask_q  <= '0;
            total_pending_q <= '0;
            wb_underflow_q  <= 1'b0;
        end else begin
            pending_mask_q  <= pending_mask_d;
            total_pending_q <= total_pending_d;
            wb_underflow_q  <= wb_underflow_d;
        end
    end

    assign pending_mask  = pending_mask_q;
    assign total_pending = total_pending_q;
    assign wb_underflow  = wb_underflow_q;

endmodule

// File: doc/regdst_scoreboard.md
Name: regdst_scoreboard

Overview:
- Consumer end of the write-register selection path: takes the 5-bit destination address chosen in decode and decodes it into per-register pending-write state.
- Tracks outstanding writes per architectural register and clears them at writeback.
- Raises a stall when an issuing instruction reads a register with a pending write, or when its destination counter is saturated.
- Sits between decode/issue and writeback of the CPU pipeline.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never pending.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS.
- CNT_W, 2, width of each per-register outstanding-write counter; saturates at 2**CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  an instruction is presented for issue this cycle.
- issue_wr  in  1  the presented instruction writes issue_dst.
- issue_dst  in  ADDR_W  destination register (write-register select result).
- issue_rs  in  ADDR_W  first source register.
- issue_rt  in  ADDR_W  second source register.
- issue_ready  out  1  instruction accepted this cycle (issue_valid & ~stall).
- stall  out  1  combinational hazard indication.
- wb_valid  in  1  a register write completes this cycle.
- wb_dst  in  ADDR_W  register being written back.
- flush  in  1  discard all outstanding state (pipeline squash).
- pending_mask  out  NUM_REGS  registered; bit i = 1 when counter i != 0.
- total_pending  out  7  registered; sum of all counters, saturating at 127.
- wb_underflow  out  1  sticky error; set on writeback to a register whose counter is 0.

Behaviour:
- Reset (async, rst_n=0): all counters 0, pending_mask=0, total_pending=0, wb_underflow=0. The outputs stall and issue_ready follow from the cleared state.
- Hazard terms (combinational, same cycle):
  - hz_rs = (issue_rs != 0) & (cnt[issue_rs] != 0)
  - hz_rt = (issue_rt != 0) & (cnt[issue_rt] != 0)
  - hz_sat = issue_wr & (issue_dst != 0) & (cnt[issue_dst] == max)
  - stall = issue_valid & (hz_rs | hz_rt | hz_sat)
  - When issue_valid=0, stall=0.
- Accept: issue_ready = issue_valid & ~stall.
- Counter updates on the rising edge:
  - Increment: an accepted issue with issue_wr=1 and issue_dst!=0 increments cnt[issue_dst].
  - Decrement: wb_valid=1 with wb_dst!=0 decrements cnt[wb_dst] if it is nonzero; if it is zero, the counter holds and wb_underflow is set.
  - Same register, same cycle (increment and decrement): net counter unchanged; no underflow even if the counter was 0.
  - Different registers, same cycle: both updates apply.
  - wb_dst=0: ignored, no error.
- Latency: 1 cycle from issue/writeback to pending_mask and total_pending.
- Flush has priority over issue and wb in the same cycle: all counters and total_pending clear to 0; wb_underflow is kept.
- wb_underflow is cleared only by reset.
- total_pending tracks increments minus decrements and always equals the sum of the counters.
- No internal FSM beyond the counter array. Every state element uses the async reset.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a source hazard is suppressed when wb_valid=1, wb_dst equals that source register, and its counter is exactly 1. The write completes this cycle and the value is forwarded, so the issue is accepted.
- Not defined: hazards depend only on the registered counters, and such an issue stalls for one extra cycle.

Test Plan:
- Reset, then issue dst=5 with wr=1 -> issue_ready=1; next cycle pending_mask=0x00000020 and total_pending=1.
- Pending r5, then issue rs=5 -> stall=1 and issue_ready=0. After wb_dst=5 the next cycle -> stall=0 and the mask clears. With WB_BYPASS_EN, stall=0 already in the wb cycle.
- Issue dst=0 with wr=1, and rs=0/rt=0 -> never stalls; pending_mask stays 0 and total_pending stays 0.
- Three accepted issues to dst=7 (counter=3), fourth issue to dst=7 -> stall=1 via saturation. wb_dst=7 -> counter=2 and the fourth issue is then accepted.
- wb_dst=9 with counter 0 -> wb_underflow=1 and stays 1. A later flush keeps it at 1; only rst_n=0 clears it.
- Pending r3 and r4, then flush together with issue dst=6 and wb_dst=3 in one cycle -> next cycle pending_mask=0 and total_pending=0. Asserting rst_n=0 mid-run clears all outputs immediately, without waiting for a clock edge.
